steering_cmd_ramp: RTL and testbench

Command sequencer that sits directly upstream of the steering PWM/H-bridge stage and produces its 32-bit control word (halt bit, direction bit, duty field). It accepts target direction/duty commands over a valid/ready handshake and slews the duty cycle toward the target at a fixed step per tick. Direction reversals are sequenced as ramp-down to zero, a halted dead-time, then ramp-up. An emergency stop forces the halted word immediately.

---
 rtl/steering_cmd_ramp.sv | 263 ++++++++++++++++++++++++++
 tb/tb_steering_cmd_ramp.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/steering_cmd_ramp.sv
// -----------------------------------------------------------------------------
// steering_cmd_ramp
//
// Command sequencer for the steering PWM/H-bridge stage. It accepts target
// direction/duty commands on a valid/ready handshake and slews the output duty
// toward the target once per ramp tick. A direction reversal is carried out as
// ramp-down to zero, a halted dead-time, then ramp-up in the new direction.
// An emergency stop forces the halted word on the next clock edge.
//
// Configuration macro:
//   STEERING_SOFTSTART_EN  defined   : duty moves by STEP per tick
//                          undefined : duty jumps to the target (or to 0 on a
//                                      reversal) on the first tick
//
// Ports:
//   clk        in   clock
//   reset      in   asynchronous, active-high reset
//   estop      in   emergency stop, level-sensitive, sampled on clk
//   cmd_valid  in   command present
//   cmd_ready  out  command accepted when cmd_valid && cmd_ready (0 in DEAD)
//   cmd_dir    in   target direction
//   cmd_duty   in   target duty (0 = stop), clamped to MAX_DUTY on accept
//   ctrl_word  out  {halt, dir, zeros, duty}
//   at_target  out  output dir/duty equal the target and not in DEAD
//   busy       out  sequencer is in RAMP or DEAD
// -----------------------------------------------------------------------------
module steering_cmd_ramp #(
    parameter int COUNT_SIZE     = 11,
    parameter int DATA_WIDTH     = 32,
    parameter int STEP           = 8,
    parameter int TICK_DIV       = 2048,
    parameter int DEADTIME_TICKS = 4,
    parameter int MAX_DUTY       = 2047
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  estop,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_dir,
    input  logic [COUNT_SIZE-1:0] cmd_duty,
    output logic [DATA_WIDTH-1:0] ctrl_word,
    output logic                  at_target,
    output logic                  busy
);

    localparam int TW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DTW = (DEADTIME_TICKS > 1) ? $clog2(DEADTIME_TICKS) : 1;
    localparam int AW  = COUNT_SIZE + 1;
    localparam int PAD = DATA_WIDTH - 2 - COUNT_SIZE;

    localparam logic [TW-1:0]         TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [DTW-1:0]        DEAD_LAST = DTW'(DEADTIME_TICKS - 1);
    localparam logic [COUNT_SIZE-1:0] MAX_W     = COUNT_SIZE'(MAX_DUTY);
    localparam logic [COUNT_SIZE-1:0] ZERO_W    = '0;

`ifdef STEERING_SOFTSTART_EN
    localparam logic [AW-1:0] STEP_W = AW'(STEP);
`else
    // Without soft-start a single step spans the whole duty range, so the
    // saturating helpers below land on the target in one tick.
    localparam logic [AW-1:0] STEP_W = AW'((STEP > (1 << COUNT_SIZE)) ? STEP : (1 << COUNT_SIZE));
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RAMP = 2'd1,
        HOLD = 2'd2,
        DEAD = 2'd3
    } state_t;

    // Increment by one step, saturating at the target (never overshoots).
    function automatic logic [COUNT_SIZE-1:0] step_up(input logic [COUNT_SIZE-1:0] cur,
                                                      input logic [COUNT_SIZE-1:0] tgt);
        logic [AW-1:0] sum_v;
        sum_v = {1'b0, cur} + STEP_W;
        if (sum_v > {1'b0, tgt}) begin
            return tgt;
        end else begin
            return sum_v[COUNT_SIZE-1:0];
        end
    endfunction

    // Decrement by one step, saturating at floor (0 for a reversal).
    function automatic logic [COUNT_SIZE-1:0] step_down(input logic [COUNT_SIZE-1:0] cur,
                                                        input logic [COUNT_SIZE-1:0] floor_v);
        logic [AW-1:0] diff_v;
        if ({1'b0, cur} >= ({1'b0, floor_v} + STEP_W)) begin
            diff_v = {1'b0, cur} - STEP_W;
            return diff_v[COUNT_SIZE-1:0];
        end else begin
            return floor_v;
        end
    endfunction

    state_t                  state_r, next_state_s;
    logic [TW-1:0]           tick_cnt_r;
    logic                    tick_s;
    logic                    tgt_dir_r, next_tgt_dir_s;
    logic [COUNT_SIZE-1:0]   tgt_duty_r, next_tgt_duty_s;
    logic                    dir_r, next_dir_s;
    logic                    halt_r, next_halt_s;
    logic [COUNT_SIZE-1:0]   duty_r, next_duty_s;
    logic [DTW-1:0]          dead_cnt_r, next_dead_cnt_s;
    logic [COUNT_SIZE-1:0]   step_s;
    logic [COUNT_SIZE-1:0]   clamp_duty_s;
    logic                    accept_s;

    assign tick_s       = (tick_cnt_r == TICK_LAST);
    assign clamp_duty_s = (cmd_duty > MAX_W) ? MAX_W : cmd_duty;
    // estop blocks acceptance in the same cycle; cmd_ready follows a cycle later.
    assign accept_s     = cmd_valid && cmd_ready && !estop;
    assign ctrl_word    = {halt_r, dir_r, {PAD{1'b0}}, duty_r};

    // Free-running ramp tick prescaler; estop deliberately leaves it running.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt_r <= '0;
        end else if (tick_s) begin
            tick_cnt_r <= '0;
        end else begin
            tick_cnt_r <= tick_cnt_r + TW'(1);
        end
    end

    // Next-state, target and output-word computation.
    always_comb begin
        next_state_s    = state_r;
        next_tgt_dir_s  = tgt_dir_r;
        next_tgt_duty_s = tgt_duty_r;
        next_dir_s      = dir_r;
        next_halt_s     = halt_r;
        next_duty_s     = duty_r;
        next_dead_cnt_s = dead_cnt_r;
        step_s          = duty_r;

        if (estop) begin
            next_state_s    = IDLE;
            next_tgt_dir_s  = 1'b0;
            next_tgt_duty_s = ZERO_W;
            next_dir_s      = 1'b0;
            next_halt_s     = 1'b1;
            next_duty_s     = ZERO_W;
            next_dead_cnt_s = '0;
        end else begin
            // The FSM below reads the old target, so an accept on a tick edge
            // only takes effect from the following tick.
            if (accept_s) begin
                next_tgt_dir_s  = cmd_dir;
                next_tgt_duty_s = clamp_duty_s;
            end else begin
                next_tgt_dir_s  = tgt_dir_r;
                next_tgt_duty_s = tgt_duty_r;
            end

            case (state_r)
                IDLE: begin
                    // No dead-time from IDLE: the bridge is already halted.
                    if (tgt_duty_r != ZERO_W) begin
                        next_state_s = RAMP;
                        next_dir_s   = tgt_dir_r;
                        next_halt_s  = 1'b0;
                    end else begin
                        next_state_s = IDLE;
                    end
                end
                RAMP: begin
                    if (!tick_s) begin
                        next_state_s = RAMP;
                    end else if (dir_r == tgt_dir_r) begin
                        if (duty_r < tgt_duty_r) begin
                            step_s = step_up(duty_r, tgt_duty_r);
                        end else begin
                            step_s = step_down(duty_r, tgt_duty_r);
                        end
                        next_duty_s = step_s;
                        if (step_s != tgt_duty_r) begin
                            next_state_s = RAMP;
                        end else if (tgt_duty_r == ZERO_W) begin
                            next_state_s = IDLE;
                            next_halt_s  = 1'b1;
                            next_dir_s   = 1'b0;
                        end else begin
                            next_state_s = HOLD;
                        end
                    end else begin
                        // Reversal: wind down to zero before switching dir.
                        step_s      = step_down(duty_r, ZERO_W);
                        next_duty_s = step_s;
                        if (step_s == ZERO_W) begin
                            next_state_s    = DEAD;
                            next_halt_s     = 1'b1;
                            next_dir_s      = 1'b0;
                            next_dead_cnt_s = '0;
                        end else begin
                            next_state_s = RAMP;
                        end
                    end
                end
                HOLD: begin
                    if ((tgt_dir_r != dir_r) || (tgt_duty_r != duty_r)) begin
                        next_state_s = RAMP;
                    end else begin
                        next_state_s = HOLD;
                    end
                end
                DEAD: begin
                    if (!tick_s) begin
                        next_state_s = DEAD;
                    end else if (dead_cnt_r == DEAD_LAST) begin
                        next_dead_cnt_s = '0;
                        if (tgt_duty_r == ZERO_W) begin
                            next_state_s = IDLE;
                        end else begin
                            next_state_s = RAMP;
                            next_dir_s   = tgt_dir_r;
                            next_halt_s  = 1'b0;
                        end
                    end else begin
                        next_dead_cnt_s = dead_cnt_r + DTW'(1);
                    end
                end
                default: begin
                    next_state_s    = IDLE;
                    next_dir_s      = 1'b0;
                    next_halt_s     = 1'b1;
                    next_duty_s     = ZERO_W;
                    next_dead_cnt_s = '0;
                end
            endcase
        end
    end

    // State, target and registered output flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= IDLE;
            tgt_dir_r  <= 1'b0;
            tgt_duty_r <= '0;
            dir_r      <= 1'b0;
            halt_r     <= 1'b1;
            duty_r     <= '0;
            dead_cnt_r <= '0;
            cmd_ready  <= 1'b1;
            at_target  <= 1'b1;
            busy       <= 1'b0;
        end else begin
            state_r    <= next_state_s;
            tgt_dir_r  <= next_tgt_dir_s;
            tgt_duty_r <= next_tgt_duty_s;
            dir_r      <= next_dir_s;
            halt_r     <= next_halt_s;
            duty_r     <= next_duty_s;
            dead_cnt_r <= next_dead_cnt_s;
            cmd_ready  <= !estop && (next_state_s != DEAD);
            // A zero-duty target is met regardless of direction.
            at_target  <= (next_state_s != DEAD) && (next_duty_s == next_tgt_duty_s) &&
                          ((next_dir_s == next_tgt_dir_s) || (next_tgt_duty_s == ZERO_W));
            busy       <= (next_state_s == RAMP) || (next_state_s == DEAD);
        end
    end

endmodule

// File: tb/tb_steering_cmd_ramp.sv
// -----------------------------------------------------------------------------
// tb_steering_cmd_ramp
//
// Directed self-checking bench for steering_cmd_ramp with STEP=8, TICK_DIV=4,
// DEADTIME_TICKS=2, MAX_DUTY=1000. Expected words are hand-computed for both
// the soft-start (STEERING_SOFTSTART_EN) and the jump build.
// -----------------------------------------------------------------------------
module tb_steering_cmd_ramp;

    logic        clk = 1'b0;
    logic        reset;
    logic        estop;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_dir;
    logic [10:0] cmd_duty;
    logic [31:0] ctrl_word;
    logic        at_target;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;   // edges since reset release; tick edges are cyc % 4 == 0

    logic [31:0] exp_up[$];
    logic [31:0] exp_rev[$];
    logic [31:0] exp_tgt[$];
    int          exp_clamp_ticks;

    steering_cmd_ramp #(
        .COUNT_SIZE    (11),
        .DATA_WIDTH    (32),
        .STEP          (8),
        .TICK_DIV      (4),
        .DEADTIME_TICKS(2),
        .MAX_DUTY      (1000)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .estop    (estop),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_dir  (cmd_dir),
        .cmd_duty (cmd_duty),
        .ctrl_word(ctrl_word),
        .at_target(at_target),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic to_tick();
        do begin
            step();
        end while (cyc % 4 != 0);
    endtask

    // Present one command for exactly one edge.
    task automatic send_cmd(input logic dir, input logic [10:0] duty);
        cmd_valid = 1'b1;
        cmd_dir   = dir;
        cmd_duty  = duty;
        step();
        cmd_valid = 1'b0;
    endtask

    initial begin
        int n;
`ifdef STEERING_SOFTSTART_EN
        exp_up.push_back(32'h40000008);
        exp_up.push_back(32'h40000010);
        exp_up.push_back(32'h40000014);
        exp_rev.push_back(32'h4000000C);
        exp_rev.push_back(32'h40000004);
        exp_rev.push_back(32'h80000000);
        exp_rev.push_back(32'h80000000);
        exp_rev.push_back(32'h00000000);
        exp_rev.push_back(32'h00000008);
        exp_rev.push_back(32'h00000010);
        exp_tgt.push_back(32'h400003E0);
        exp_tgt.push_back(32'h400003D8);
        exp_tgt.push_back(32'h400003E0);
        exp_clamp_ticks = 125;
`else
        exp_up.push_back(32'h40000014);
        exp_rev.push_back(32'h80000000);
        exp_rev.push_back(32'h80000000);
        exp_rev.push_back(32'h00000000);
        exp_rev.push_back(32'h00000010);
        exp_tgt.push_back(32'h400003C0);
        exp_tgt.push_back(32'h400003C0);
        exp_tgt.push_back(32'h400003E8);
        exp_clamp_ticks = 1;
`endif
        reset     = 1'b0;
        estop     = 1'b0;
        cmd_valid = 1'b0;
        cmd_dir   = 1'b0;
        cmd_duty  = 11'd0;

        // Power-on reset values
        #2 reset = 1'b1;
        #1;
        check_eq("rst_word", ctrl_word, 32'h80000000);
        check_eq("rst_ready", 32'(cmd_ready), 32'd1);
        check_eq("rst_at_target", 32'(at_target), 32'd1);
        check_eq("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        cyc   = 0;
        to_tick();
        check_eq("idle_word", ctrl_word, 32'h80000000);

        // Ramp up from IDLE: dir=1 duty=20
        send_cmd(1'b1, 11'd20);
        check_eq("acc_at_target", 32'(at_target), 32'd0);
        step();
        check_eq("start_word", ctrl_word, 32'h40000000);
        check_eq("start_busy", 32'(busy), 32'd1);
        foreach (exp_up[i]) begin
            to_tick();
            check_eq($sformatf("up_%0d", i), ctrl_word, exp_up[i]);
        end
        check_eq("up_at_target", 32'(at_target), 32'd1);
        check_eq("up_busy", 32'(busy), 32'd0);

        // Reversal to dir=0 duty=16 with dead-time
        send_cmd(1'b0, 11'd16);
        foreach (exp_rev[i]) begin
            to_tick();
            check_eq($sformatf("rev_%0d", i), ctrl_word, exp_rev[i]);
            check_eq($sformatf("rev_ready_%0d", i), 32'(cmd_ready),
                     (exp_rev[i] == 32'h80000000) ? 32'd0 : 32'd1);
        end
        check_eq("rev_at_target", 32'(at_target), 32'd1);

        // estop while ramping from duty 16; command during estop is ignored
        send_cmd(1'b0, 11'd40);
        step();
        check_eq("pre_estop_word", ctrl_word, 32'h00000010);
        estop     = 1'b1;
        cmd_valid = 1'b1;
        cmd_dir   = 1'b1;
        cmd_duty  = 11'd100;
        step();
        check_eq("estop_word", ctrl_word, 32'h80000000);
        check_eq("estop_ready", 32'(cmd_ready), 32'd0);
        check_eq("estop_busy", 32'(busy), 32'd0);
        step();
        check_eq("estop_ready_hold", 32'(cmd_ready), 32'd0);
        estop     = 1'b0;
        cmd_valid = 1'b0;
        to_tick();
        to_tick();
        check_eq("post_estop_word", ctrl_word, 32'h80000000);
        check_eq("post_estop_at_target", 32'(at_target), 32'd1);

        // Clamp: duty 2047 limited to MAX_DUTY=1000
        send_cmd(1'b1, 11'd2047);
        n = 0;
        while (n < 200 && ctrl_word != 32'h400003E8) begin
            to_tick();
            n++;
        end
        check_eq("clamp_ticks", 32'(n), 32'(exp_clamp_ticks));
        check_eq("clamp_word", ctrl_word, 32'h400003E8);
        to_tick();
        check_eq("clamp_no_overshoot", ctrl_word, 32'h400003E8);
        check_eq("clamp_at_target", 32'(at_target), 32'd1);

        // Accept coinciding with a tick uses the old target on that tick
        send_cmd(1'b1, 11'd960);
        to_tick();
        check_eq("tick_acc_0", ctrl_word, exp_tgt[0]);
        step();
        step();
        step();
        send_cmd(1'b1, 11'd1000);
        check_eq("tick_acc_1", ctrl_word, exp_tgt[1]);
        to_tick();
        check_eq("tick_acc_2", ctrl_word, exp_tgt[2]);

        // Asynchronous reset in the middle of a ramp
        send_cmd(1'b1, 11'd200);
        step();
        check_eq("pre_reset_busy", 32'(busy), 32'd1);
        #3 reset = 1'b1;
        #1;
        check_eq("mid_rst_word", ctrl_word, 32'h80000000);
        check_eq("mid_rst_ready", 32'(cmd_ready), 32'd1);
        check_eq("mid_rst_at_target", 32'(at_target), 32'd1);
        check_eq("mid_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        cyc   = 0;
        to_tick();
        to_tick();
        check_eq("after_rst_word", ctrl_word, 32'h80000000);
        check_eq("after_rst_busy", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
